// File: rtl/char_overlay_multi.sv
// char_overlay_multi
//   On-screen overlay for the LCD video path. Draws NUM_CHARS hex-digit glyphs,
//   one bounding-box outline and an optional screen border over the incoming
//   RGB888 stream. Digit codes, box and flags are written into a shadow copy
//   through a valid/ready handshake. The shadow copy moves to the active set only
//   at frame start (rising edge of i_vs), so a frame is never drawn half old and
//   half new. Each digit can blink with a half-period of BLINK_FRAMES frames. Its
//   background can be opaque (BG_COLOR) or transparent (video shows through).
//   Two register stages. Every output is the input delayed by exactly 2 cycles.
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   x, y                pixel coordinates aligned with i_de/i_data
//   i_hs, i_vs, i_de    input timing (active-high)
//   i_data              input RGB888
//   cfg_valid/ready     config handshake (capture on valid & ready)
//   cfg_chars           4-bit hex codes, char0 in [3:0] = leftmost cell
//   cfg_blink           per-char blink enable
//   cfg_box             {left,right,up,down}, 12 bits each
//   cfg_box_en          draw box outline
//   cfg_flags           [0] border enable, [1] transparent glyph background
//   o_hs, o_vs, o_de    timing delayed by 2 cycles
//   o_data              composited RGB888 (black while o_de = 0)
module char_overlay_multi #(
  parameter int unsigned NUM_CHARS    = 5,
  parameter int unsigned SCALE_LSB    = 2,
  parameter int unsigned POS_X        = 0,
  parameter int unsigned POS_Y        = 0,
  parameter int unsigned H_ACTIVE     = 480,
  parameter int unsigned V_ACTIVE     = 272,
  parameter logic [23:0] FG_COLOR     = 24'hffffff,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter logic [23:0] BOX_COLOR    = 24'hff0000,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            x,
  input  logic [11:0]            y,
  input  logic                   i_hs,
  input  logic                   i_vs,
  input  logic                   i_de,
  input  logic [23:0]            i_data,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [4*NUM_CHARS-1:0] cfg_chars,
  input  logic [NUM_CHARS-1:0]   cfg_blink,
  input  logic [47:0]            cfg_box,
  input  logic                   cfg_box_en,
  input  logic [1:0]             cfg_flags,
  output logic                   o_hs,
  output logic                   o_vs,
  output logic                   o_de,
  output logic [23:0]            o_data
);

  localparam int unsigned CELL_H = 16 << SCALE_LSB;
  localparam int unsigned FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {PH_VISIBLE = 1'b0, PH_HIDDEN = 1'b1} phase_e;

  // Seven-segment style hex font in an 8x16 cell. The MSB is the top-left pixel.
  // Segment bits: [0]a top, [1]b upper-right, [2]c lower-right, [3]d bottom,
  // [4]e lower-left, [5]f upper-left, [6]g middle.
  function automatic logic [127:0] char_array_decode(input logic [3:0] code);
    logic [6:0]   seg;
    logic [127:0] g;
    logic         on;
    case (code)
      4'h0: seg = 7'h3f;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5b;  4'h3: seg = 7'h4f;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6d;  4'h6: seg = 7'h7d;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7f;  4'h9: seg = 7'h6f;  4'ha: seg = 7'h77;  4'hb: seg = 7'h7c;
      4'hc: seg = 7'h39;  4'hd: seg = 7'h5e;  4'he: seg = 7'h79;  default: seg = 7'h71;
    endcase
    g = '0;
    for (int unsigned r = 0; r < 16; r++) begin
      for (int unsigned c = 0; c < 8; c++) begin
        on = 1'b0;
        if (seg[0] && r == 1  && c >= 2 && c <= 5)  on = 1'b1;
        if (seg[1] && c == 6  && r >= 2 && r <= 6)  on = 1'b1;
        if (seg[2] && c == 6  && r >= 9 && r <= 13) on = 1'b1;
        if (seg[3] && r == 14 && c >= 2 && c <= 5)  on = 1'b1;
        if (seg[4] && c == 1  && r >= 9 && r <= 13) on = 1'b1;
        if (seg[5] && c == 1  && r >= 2 && r <= 6)  on = 1'b1;
        if (seg[6] && r == 7  && c >= 2 && c <= 5)  on = 1'b1;
        g[7'(127 - (8 * r + c))] = on;
      end
    end
    return g;
  endfunction

  // ---------------- configuration, frame start, blink ----------------
  logic                   vs_q, vs_d;
  logic                   pending_q, pending_d;
  logic [4*NUM_CHARS-1:0] sh_chars_q, sh_chars_d, act_chars_q, act_chars_d;
  logic [NUM_CHARS-1:0]   sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
  logic [47:0]            sh_box_q, sh_box_d, act_box_q, act_box_d;
  logic                   sh_box_en_q, sh_box_en_d, act_box_en_q, act_box_en_d;
  logic [1:0]             sh_flags_q, sh_flags_d, act_flags_q, act_flags_d;
  logic [FC_W-1:0]        frame_cnt_q, frame_cnt_d;
  phase_e                 phase_q, phase_d;
  logic                   frame_start, cfg_fire;

  assign cfg_ready = ~pending_q;

  always_comb begin
    frame_start  = i_vs & ~vs_q;
    // A capture needs pending = 0. So a capture can never meet a pending copy
    // in the same cycle. The new shadow always waits for the next frame start.
    cfg_fire     = cfg_valid & ~pending_q;
    vs_d         = i_vs;
    pending_d    = pending_q;
    sh_chars_d   = sh_chars_q;
    sh_blink_d   = sh_blink_q;
    sh_box_d     = sh_box_q;
    sh_box_en_d  = sh_box_en_q;
    sh_flags_d   = sh_flags_q;
    act_chars_d  = act_chars_q;
    act_blink_d  = act_blink_q;
    act_box_d    = act_box_q;
    act_box_en_d = act_box_en_q;
    act_flags_d  = act_flags_q;
    frame_cnt_d  = frame_cnt_q;
    phase_d      = phase_q;

    if (frame_start) begin
      if (pending_q) begin
        act_chars_d  = sh_chars_q;
        act_blink_d  = sh_blink_q;
        act_box_d    = sh_box_q;
        act_box_en_d = sh_box_en_q;
        act_flags_d  = sh_flags_q;
        pending_d    = 1'b0;
      end
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end

    if (cfg_fire) begin
      sh_chars_d  = cfg_chars;
      sh_blink_d  = cfg_blink;
      sh_box_d    = cfg_box;
      sh_box_en_d = cfg_box_en;
      sh_flags_d  = cfg_flags;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q         <= 1'b0;
      pending_q    <= 1'b0;
      sh_chars_q   <= '0;
      sh_blink_q   <= '0;
      sh_box_q     <= '0;
      sh_box_en_q  <= 1'b0;
      sh_flags_q   <= '0;
      act_chars_q  <= '0;
      act_blink_q  <= '0;
      act_box_q    <= '0;
      act_box_en_q <= 1'b0;
      act_flags_q  <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= PH_VISIBLE;
    end else begin
      vs_q         <= vs_d;
      pending_q    <= pending_d;
      sh_chars_q   <= sh_chars_d;
      sh_blink_q   <= sh_blink_d;
      sh_box_q     <= sh_box_d;
      sh_box_en_q  <= sh_box_en_d;
      sh_flags_q   <= sh_flags_d;
      act_chars_q  <= act_chars_d;
      act_blink_q  <= act_blink_d;
      act_box_q    <= act_box_d;
      act_box_en_q <= act_box_en_d;
      act_flags_q  <= act_flags_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
    end
  end

  // ---------------- stage 1: region hits and glyph coordinates ----------------
  logic [12:0] dx, dy;
  logic [2:0]  cell_idx;
  logic [4*NUM_CHARS-1:0] chars_sh;
  logic [NUM_CHARS-1:0]   blink_sh;
  logic        in_row, in_col, blinked;
  logic [11:0] bx_l, bx_r, bx_u, bx_d;
  logic        box_ok, on_vert, on_horz;

  logic        s1_border_q, s1_border_d;
  logic        s1_box_q, s1_box_d;
  logic        s1_cell_q, s1_cell_d;
  logic [3:0]  s1_code_q, s1_code_d;
  logic [2:0]  s1_gx_q, s1_gx_d;
  logic [3:0]  s1_gy_q, s1_gy_d;
  logic        s1_transp_q, s1_transp_d;
  logic [23:0] s1_data_q, s1_data_d;
  logic        s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_de_q, s1_de_d;

  always_comb begin
    // 13-bit offsets. Bit 12 set means the pixel is left of or above the row.
    dx       = {1'b0, x} - 13'(POS_X);
    dy       = {1'b0, y} - 13'(POS_Y);
    // Cells are a power of two wide. So the cell index is just the upper bits of dx.
    cell_idx = 3'(dx >> (3 + SCALE_LSB));
    in_row   = ~dy[12] && (dy < 13'(CELL_H));
    in_col   = ~dx[12] && ((dx >> (3 + SCALE_LSB)) < 13'(NUM_CHARS));
    chars_sh = act_chars_q >> {cell_idx, 2'b00};
    blink_sh = act_blink_q >> cell_idx;
    blinked  = blink_sh[0] && (phase_q == PH_HIDDEN);

    bx_l    = act_box_q[47:36];
    bx_r    = act_box_q[35:24];
    bx_u    = act_box_q[23:12];
    bx_d    = act_box_q[11:0];
    box_ok  = act_box_en_q && (bx_l <= bx_r) && (bx_u <= bx_d);
    on_vert = ((x == bx_l) || (x == bx_r)) && (y >= bx_u) && (y <= bx_d);
    on_horz = ((y == bx_u) || (y == bx_d)) && (x >= bx_l) && (x <= bx_r);

    s1_border_d = act_flags_q[0] &&
                  ((x == 12'd1) || (x == 12'(H_ACTIVE)) ||
                   (y == 12'd0) || (y == 12'(V_ACTIVE - 1)));
    s1_box_d    = box_ok && (on_vert || on_horz);
    s1_cell_d   = in_row && in_col && !blinked;
    s1_code_d   = chars_sh[3:0];
    s1_gx_d     = 3'(dx >> SCALE_LSB);
    s1_gy_d     = 4'(dy >> SCALE_LSB);
    s1_transp_d = act_flags_q[1];
    s1_data_d   = i_data;
    s1_hs_d     = i_hs;
    s1_vs_d     = i_vs;
    s1_de_d     = i_de;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_border_q <= 1'b0;
      s1_box_q    <= 1'b0;
      s1_cell_q   <= 1'b0;
      s1_code_q   <= '0;
      s1_gx_q     <= '0;
      s1_gy_q     <= '0;
      s1_transp_q <= 1'b0;
      s1_data_q   <= '0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_de_q     <= 1'b0;
    end else begin
      s1_border_q <= s1_border_d;
      s1_box_q    <= s1_box_d;
      s1_cell_q   <= s1_cell_d;
      s1_code_q   <= s1_code_d;
      s1_gx_q     <= s1_gx_d;
      s1_gy_q     <= s1_gy_d;
      s1_transp_q <= s1_transp_d;
      s1_data_q   <= s1_data_d;
      s1_hs_q     <= s1_hs_d;
      s1_vs_q     <= s1_vs_d;
      s1_de_q     <= s1_de_d;
    end
  end

  // ---------------- stage 2: glyph lookup and priority mux ----------------
  logic [127:0] glyph;
  logic         glyph_bit;
  logic [23:0]  o_data_q, o_data_d;
  logic         o_hs_q, o_vs_q, o_de_q;

  always_comb begin
    glyph     = char_array_decode(s1_code_q);
    // The bit index is 127 - (8*gy + gx). That equals the inverse of {gy,gx}.
    glyph_bit = glyph[~{s1_gy_q, s1_gx_q}];
    if (!s1_de_q)         o_data_d = '0;
    else if (s1_border_q) o_data_d = BOX_COLOR;
    else if (s1_box_q)    o_data_d = BOX_COLOR;
    else if (s1_cell_q)   o_data_d = glyph_bit ? FG_COLOR : (s1_transp_q ? s1_data_q : BG_COLOR);
    else                  o_data_d = s1_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data_q <= '0;
      o_hs_q   <= 1'b0;
      o_vs_q   <= 1'b0;
      o_de_q   <= 1'b0;
    end else begin
      o_data_q <= o_data_d;
      o_hs_q   <= s1_hs_q;
      o_vs_q   <= s1_vs_q;
      o_de_q   <= s1_de_q;
    end
  end

  assign o_data = o_data_q;
  assign o_hs   = o_hs_q;
  assign o_vs   = o_vs_q;
  assign o_de   = o_de_q;

endmodule

// File: tb/tb_char_overlay_multi.sv
module tb_char_overlay_multi;
  localparam int NC = 5, S = 0, PX = 10, PY = 8, HA = 64, VA = 40, BF = 2;
  localparam int HT = 72, VT = 44;
  localparam int CW = 8 << S, CH = 16 << S;
  localparam logic [23:0] FG = 24'hffffff, BG = 24'h102030, BOXC = 24'hff0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] x, y;
  logic        i_hs, i_vs, i_de;
  logic [23:0] i_data;
  logic        cfg_valid, cfg_ready;
  logic [19:0] cfg_chars;
  logic [4:0]  cfg_blink;
  logic [47:0] cfg_box;
  logic        cfg_box_en;
  logic [1:0]  cfg_flags;
  logic        o_hs, o_vs, o_de;
  logic [23:0] o_data;

  always #5 clk = ~clk;

  char_overlay_multi #(
    .NUM_CHARS(NC), .SCALE_LSB(S), .POS_X(PX), .POS_Y(PY),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .FG_COLOR(FG), .BG_COLOR(BG),
    .BOX_COLOR(BOXC), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_data(i_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chars(cfg_chars), .cfg_blink(cfg_blink), .cfg_box(cfg_box),
    .cfg_box_en(cfg_box_en), .cfg_flags(cfg_flags),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data)
  );

  typedef struct {
    logic [19:0] chars;
    logic [4:0]  blink;
    logic [47:0] box;
    logic        box_en;
    logic [1:0]  flags;
  } cfg_t;

  typedef struct {
    int          due;
    logic [26:0] exp;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  bit   mon_en = 0;

  // reference model state
  cfg_t m_act, m_sh;
  bit   m_pending;
  int   m_nframes;
  bit   m_vs_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic cfg_t zero_cfg();
    cfg_t c;
    c.chars = '0; c.blink = '0; c.box = '0; c.box_en = 1'b0; c.flags = '0;
    return c;
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    int l, r, u, d;
    l = $urandom_range(0, 60); r = $urandom_range(l, 70);
    u = $urandom_range(0, 35); d = $urandom_range(u, 43);
    c.chars  = 20'($urandom);
    c.blink  = 5'($urandom);
    c.box    = {12'(l), 12'(r), 12'(u), 12'(d)};
    c.box_en = 1'($urandom);
    c.flags  = 2'($urandom);
    return c;
  endfunction

  // Seven-segment hex digit in an 8x16 cell, tested pixel by pixel from the segment geometry.
  function automatic bit seg_on(input logic [3:0] code, input int c, input int r);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h3f;  4'h1: s = 7'h06;  4'h2: s = 7'h5b;  4'h3: s = 7'h4f;
      4'h4: s = 7'h66;  4'h5: s = 7'h6d;  4'h6: s = 7'h7d;  4'h7: s = 7'h07;
      4'h8: s = 7'h7f;  4'h9: s = 7'h6f;  4'ha: s = 7'h77;  4'hb: s = 7'h7c;
      4'hc: s = 7'h39;  4'hd: s = 7'h5e;  4'he: s = 7'h79;  default: s = 7'h71;
    endcase
    if (s[0] && r == 1  && c inside {[2:5]})  return 1;
    if (s[1] && c == 6  && r inside {[2:6]})  return 1;
    if (s[2] && c == 6  && r inside {[9:13]}) return 1;
    if (s[3] && r == 14 && c inside {[2:5]})  return 1;
    if (s[4] && c == 1  && r inside {[9:13]}) return 1;
    if (s[5] && c == 1  && r inside {[2:6]})  return 1;
    if (s[6] && r == 7  && c inside {[2:5]})  return 1;
    return 0;
  endfunction

  function automatic logic [23:0] ref_pixel(input int px, input int py, input logic [23:0] d,
                                            input cfg_t c, input bit hidden);
    int l, r, u, dn, x0;
    l = int'(c.box[47:36]); r = int'(c.box[35:24]); u = int'(c.box[23:12]); dn = int'(c.box[11:0]);
    if (c.flags[0] && (px == 1 || px == HA || py == 0 || py == VA - 1)) return BOXC;
    if (c.box_en && l <= r && u <= dn &&
        (((px == l || px == r) && py >= u && py <= dn) ||
         ((py == u || py == dn) && px >= l && px <= r))) return BOXC;
    for (int k = 0; k < NC; k++) begin
      x0 = PX + k * CW;
      if (px >= x0 && px < x0 + CW && py >= PY && py < PY + CH) begin
        if (c.blink[k] && hidden) return d;
        if (seg_on(c.chars[4*k +: 4], (px - x0) / (1 << S), (py - PY) / (1 << S))) return FG;
        return c.flags[1] ? d : BG;
      end
    end
    return d;
  endfunction

  task automatic model_reset();
    m_act = zero_cfg(); m_sh = zero_cfg();
    m_pending = 0; m_nframes = 0; m_vs_prev = 0;
  endtask

  task automatic drive_cycle(input int px, input int py, input bit v, input cfg_t cv);
    bit          hid, fs, acc;
    logic [23:0] ed;
    @(negedge clk);
    check("cfg_ready", 64'(cfg_ready), 64'(!m_pending));
    x = 12'(px); y = 12'(py);
    i_de   = (px >= 1 && px <= HA && py < VA);
    i_hs   = (px >= 66 && px <= 69);
    i_vs   = (py == 41 || py == 42);
    i_data = 24'($urandom);
    cfg_valid = v; cfg_chars = cv.chars; cfg_blink = cv.blink;
    cfg_box = cv.box; cfg_box_en = cv.box_en; cfg_flags = cv.flags;
    hid = ((m_nframes / BF) % 2) == 1;
    ed  = i_de ? ref_pixel(px, py, i_data, m_act, hid) : 24'h0;
    q.push_back('{due: cyc + 2, exp: {i_hs, i_vs, i_de, ed}});
    // advance the model across the coming clock edge
    acc = v && !m_pending;
    fs  = i_vs && !m_vs_prev;
    if (fs) begin
      if (m_pending) begin m_act = m_sh; m_pending = 0; end
      m_nframes++;
    end
    if (acc) begin m_sh = cv; m_pending = 1; end
    m_vs_prev = i_vs;
  endtask

  // monitor: pops the expectation due this cycle and compares it with the DUT outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_en) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          check("pixel", 64'({o_hs, o_vs, o_de, o_data}), 64'(e.exp));
        end
      end
    end
  end

  task automatic run_frame(input int fi, input int last_y);
    cfg_t a, b, cv;
    bit   v;
    a.chars = 20'h1234A; a.blink = 5'b0; a.box = {12'd20, 12'd40, 12'd5, 12'd30};
    a.box_en = 1'b1; a.flags = 2'b01;
    b.chars = 20'($urandom); b.blink = 5'b00001; b.box = {12'd40, 12'd20, 12'd5, 12'd30};
    b.box_en = 1'b1; b.flags = 2'b11;
    for (int py = 0; py <= last_y; py++) begin
      for (int px = 0; px < HT; px++) begin
        v = 0; cv = rand_cfg();
        if (fi == 0 && py == 20 && px == 30) begin v = 1; cv = a; end
        if (fi == 0 && py == 30 && px == 5) v = 1;   // offered while busy, must be ignored
        if (fi == 1 && py == 41 && px == 0) begin v = 1; cv = b; end  // same cycle as vs rise
        if (fi >= 4 && fi <= 6 && py == 10 && px == 0) v = 1;
        drive_cycle(px, py, v, cv);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; x = '0; y = '0; i_hs = 0; i_vs = 0; i_de = 0; i_data = '0;
    cfg_valid = 0; cfg_chars = '0; cfg_blink = '0; cfg_box = '0; cfg_box_en = 0; cfg_flags = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({o_hs, o_vs, o_de, o_data}), 64'h0);
    check("reset_cfg_ready", 64'(cfg_ready), 64'h1);
    rst_n = 1'b1;
    mon_en = 1;

    for (int fi = 0; fi < 8; fi++) run_frame(fi, VT - 1);
    run_frame(8, 20);

    // asynchronous reset in the middle of an active line
    @(negedge clk);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", 64'({o_hs, o_vs, o_de, o_data}), 64'h0);
    check("midreset_cfg_ready", 64'(cfg_ready), 64'h1);
    q.delete();
    repeat (2) @(negedge clk);
    check("midreset_hold", 64'({o_hs, o_vs, o_de, o_data}), 64'h0);
    x = '0; y = '0; i_hs = 0; i_vs = 0; i_de = 0; cfg_valid = 0;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1;
    run_frame(9, VT - 1);
    run_frame(10, 25);

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
